// File: rtl/tempsense_ctrl.sv
// Delay-cell temperature sensor controller: precharge, release, count cycles until the cell fires.
// Optional build macro TEMPSENSE_AVG_EN: four passes per request, result is the truncated mean.
module tempsense_ctrl #(
    parameter int N_VDAC     = 6,
    parameter int N_CNT      = 12,
    parameter int PRE_CYCLES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [N_VDAC-1:0] i_dac_code,
    output logic [N_VDAC-1:0] o_dac,
    output logic              o_en,
    output logic              o_meas,
    input  logic              i_res,
    output logic [N_CNT-1:0]  o_result,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_overflow
);
    localparam int PW = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PRECHARGE, MEASURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [N_CNT-1:0]  cnt_q, cnt_d;
    logic              res_s1_q, res_s2_q;
    logic [N_VDAC-1:0] dac_q, dac_d;
    logic              en_q, en_d, meas_q, meas_d, busy_q, busy_d;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic [N_CNT-1:0]  result_q, result_d;
    logic              pass_done, pass_to;
    logic [N_CNT-1:0]  pass_val;
`ifdef TEMPSENSE_AVG_EN
    logic [1:0]        pass_q, pass_d;
    logic [N_CNT+1:0]  acc_q, acc_d, acc_sum;
    logic              ovf_any_q, ovf_any_d;
`endif

    // Cell output is asynchronous; synchronizer runs in every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_s1_q <= 1'b0;
            res_s2_q <= 1'b0;
        end else begin
            res_s1_q <= i_res;
            res_s2_q <= res_s1_q;
        end
    end

    // Sync test wins over the timeout when both hit in the same cycle.
    assign pass_to   = !res_s2_q && (cnt_q == {N_CNT{1'b1}});
    assign pass_done = res_s2_q || pass_to;
    assign pass_val  = res_s2_q ? cnt_q : {N_CNT{1'b1}};
`ifdef TEMPSENSE_AVG_EN
    assign acc_sum   = acc_q + {2'b00, pass_val};
`endif

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        dac_d    = dac_q;
        en_d     = en_q;
        meas_d   = meas_q;
        busy_d   = busy_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
`ifdef TEMPSENSE_AVG_EN
        pass_d    = pass_q;
        acc_d     = acc_q;
        ovf_any_d = ovf_any_q;
`endif
        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                meas_d = 1'b0;
                busy_d = 1'b0;
                if (i_start) begin
                    dac_d   = i_dac_code;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    pre_d   = '0;
                    state_d = PRECHARGE;
`ifdef TEMPSENSE_AVG_EN
                    pass_d    = '0;
                    acc_d     = '0;
                    ovf_any_d = 1'b0;
`endif
                end
            end
            PRECHARGE: begin
                if (pre_q == PW'(PRE_CYCLES - 1)) begin
                    meas_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = MEASURE;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!pass_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
`ifdef TEMPSENSE_AVG_EN
                    if (pass_q == 2'd3) begin
                        result_d = acc_sum[N_CNT+1:2];
                        ovf_d    = ovf_any_q | pass_to;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        acc_d     = acc_sum;
                        ovf_any_d = ovf_any_q | pass_to;
                        pass_d    = pass_q + 1'b1;
                        meas_d    = 1'b0;
                        pre_d     = '0;
                        state_d   = PRECHARGE;
                    end
`else
                    result_d = pass_val;
                    ovf_d    = pass_to;
                    valid_d  = 1'b1;
                    state_d  = DONE;
`endif
                end
            end
            DONE: begin
                meas_d  = 1'b0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            dac_q    <= '0;
            en_q     <= 1'b0;
            meas_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            en_q     <= en_d;
            meas_q   <= meas_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

`ifdef TEMPSENSE_AVG_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pass_q    <= '0;
            acc_q     <= '0;
            ovf_any_q <= 1'b0;
        end else begin
            pass_q    <= pass_d;
            acc_q     <= acc_d;
            ovf_any_q <= ovf_any_d;
        end
    end
`endif

    assign o_dac      = dac_q;
    assign o_en       = en_q;
    assign o_meas     = meas_q;
    assign o_busy     = busy_q;
    assign o_result   = result_q;
    assign o_overflow = ovf_q;
    assign o_valid    = valid_q;
endmodule
